text_scroll_controller: RTL and testbench

- Owns the `top_row` value driven into the text-mode timing block.
- Sequences two operations on the 32-row circular text buffer:
  - Scroll up by one line: blank the recycled row, then advance `top_row`.
  - Clear screen: blank all 32 rows, then set `top_row` to 0.
- Blanking writes go out through a valid/ready write port to the text RAM arbiter.
- Every `top_row` change is committed only at a frame boundary, so the display never tears mid-frame.

---
 rtl/text_scroll_controller.sv | 199 +++++++++++++++++++
 tb/tb_text_scroll_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/text_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module      : text_scroll_controller
// Description : Owns the top_row pointer of a 32-row circular text buffer
//               and sequences two operations on it:
//                 - scroll up one line: blank the row that is about to
//                   become visible at the bottom, then advance top_row;
//                 - clear screen: blank all 32 physical rows, then reset
//                   top_row to 0.
//               Blanking writes go out on a valid/ready port.  Every
//               top_row change is held back until a frame_start pulse
//               arrives, so the display never tears mid-frame.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               frame_start      - one-cycle pulse at start of vblank
//               scroll_req       - level request, scroll up one line
//               clear_req        - level request, clear whole screen
//               ack              - one-cycle pulse when operation commits
//               busy             - high whenever an operation is in flight
//               top_row          - physical row shown at the screen top
//               wr_valid/ready   - blanking write handshake
//               wr_row/col/data  - blanking write address and character
// Revision    : 1.0 - initial release
// ============================================================================
module text_scroll_controller #(
   parameter int         ROWS       = 24,
   parameter int         COLS       = 80,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       scroll_req,
   input  logic       clear_req,
   output logic       ack,
   output logic       busy,
   output logic [4:0] top_row,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [4:0] wr_row,
   output logic [6:0] wr_col,
   output logic [7:0] wr_data
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // Offset from top_row to the first row that is not yet visible; that is
   // the row recycled by a scroll.  The 5-bit truncation gives mod-32 wrap.
   localparam logic [4:0] c_ROW_OFS  = 5'(ROWS);
   localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] c_LAST_ROW = 5'd31;

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLR_LINE   = 3'd1,
      S_CLR_ALL    = 3'd2,
      S_WAIT_FRAME = 3'd3,
      S_DONE       = 3'd4
   } state_t;

   state_t     state_q,    state_d;
   logic       op_clear_q, op_clear_d;   // 1: clear in flight, 0: scroll
   logic [4:0] top_row_q,  top_row_d;
   logic       ack_q,      ack_d;
   logic       busy_q,     busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic [4:0] wr_row_q,   wr_row_d;
   logic [6:0] wr_col_q,   wr_col_d;
   logic [7:0] wr_data_q;

   // A blanking write retires on this cycle.
   logic       w_wr_done;
   logic       w_last_col;

   assign w_wr_done  = wr_valid_q & wr_ready;
   assign w_last_col = (wr_col_q == c_LAST_COL);

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      op_clear_d = op_clear_q;
      top_row_d  = top_row_q;
      ack_d      = 1'b0;
      wr_valid_d = wr_valid_q;
      wr_row_d   = wr_row_q;
      wr_col_d   = wr_col_q;

      unique case (state_q)
         S_IDLE: begin
            // Clear has priority; a simultaneous scroll request stays
            // pending and is picked up once the clear has been acked.
            if (clear_req) begin
               state_d    = S_CLR_ALL;
               op_clear_d = 1'b1;
               wr_row_d   = 5'd0;
               wr_col_d   = 7'd0;
               wr_valid_d = 1'b1;
            end else if (scroll_req) begin
               state_d    = S_CLR_LINE;
               op_clear_d = 1'b0;
               wr_row_d   = top_row_q + c_ROW_OFS;
               wr_col_d   = 7'd0;
               wr_valid_d = 1'b1;
            end
         end

         S_CLR_LINE: begin
            if (w_wr_done) begin
               if (w_last_col) begin
                  wr_valid_d = 1'b0;
                  state_d    = S_WAIT_FRAME;
               end else begin
                  wr_col_d = wr_col_q + 7'd1;
               end
            end
         end

         S_CLR_ALL: begin
            if (w_wr_done) begin
               if (w_last_col) begin
                  if (wr_row_q == c_LAST_ROW) begin
                     wr_valid_d = 1'b0;
                     state_d    = S_WAIT_FRAME;
                  end else begin
                     wr_col_d = 7'd0;
                     wr_row_d = wr_row_q + 5'd1;
                  end
               end else begin
                  wr_col_d = wr_col_q + 7'd1;
               end
            end
         end

         S_WAIT_FRAME: begin
            // Commit only at the frame boundary; earlier frame_start
            // pulses (seen while still blanking) were ignored.
            if (frame_start) begin
               top_row_d = op_clear_q ? 5'd0 : (top_row_q + 5'd1);
               ack_d     = 1'b1;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d    = S_IDLE;
            wr_valid_d = 1'b0;
         end
      endcase

      // busy is registered, so it is derived from the state being entered.
      busy_d = (state_d != S_IDLE);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_clear_q <= 1'b0;
         top_row_q  <= 5'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_row_q   <= 5'd0;
         wr_col_q   <= 7'd0;
         wr_data_q  <= BLANK_CHAR;
      end else begin
         state_q    <= state_d;
         op_clear_q <= op_clear_d;
         top_row_q  <= top_row_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_row_q   <= wr_row_d;
         wr_col_q   <= wr_col_d;
         wr_data_q  <= BLANK_CHAR;
      end
   end

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign top_row  = top_row_q;
   assign wr_valid = wr_valid_q;
   assign wr_row   = wr_row_q;
   assign wr_col   = wr_col_q;
   assign wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_text_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_scroll_controller
// Description : Directed self-checking bench for text_scroll_controller
//               (ROWS=24, COLS=80, BLANK_CHAR=8'h20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_scroll_controller;

   localparam int         c_COLS  = 80;
   localparam logic [4:0] c_ROWS5 = 5'd24;
   localparam logic [7:0] c_BLANK = 8'h20;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic       scroll_req;
   logic       clear_req;
   logic       ack;
   logic       busy;
   logic [4:0] top_row;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_row;
   logic [6:0] wr_col;
   logic [7:0] wr_data;

   int n_tests = 0;
   int n_fail  = 0;

   text_scroll_controller #(
      .ROWS       (24),
      .COLS       (c_COLS),
      .BLANK_CHAR (8'h20)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .scroll_req  (scroll_req),
      .clear_req   (clear_req),
      .ack         (ack),
      .busy        (busy),
      .top_row     (top_row),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .wr_data     (wr_data)
   );

   always #5 clk = ~clk;

   // Outputs are sampled and inputs driven 1 time unit after each edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Follows a sweep that was accepted on the previous edge.  Each sample
   // is checked against the expected (row, col) for the current write
   // index; the index only advances on a handshake, so stalled cycles must
   // present the same address again.
   task automatic sweep(input bit clr, input logic [4:0] row0,
                        input logic [4:0] top_keep, input bit rnd, input bit fsn);
      int total;
      int idx;
      int cyc;
      logic rdy;
      logic [4:0] erow;
      logic [6:0] ecol;
      total = clr ? 32 * c_COLS : c_COLS;
      idx   = 0;
      cyc   = 0;
      while (idx < total && cyc < total * 4 + 50) begin
         rdy         = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_ready    = rdy;
         frame_start = fsn ? 1'($urandom_range(0, 1)) : 1'b0;
         erow        = clr ? 5'(idx / c_COLS) : row0;
         ecol        = 7'(idx % c_COLS);
         if (wr_valid !== 1'b1) begin
            chk("sweep_valid", {31'd0, wr_valid}, 32'd1);
            break;
         end
         chk("wr_row",  {27'd0, wr_row},  {27'd0, erow});
         chk("wr_col",  {25'd0, wr_col},  {25'd0, ecol});
         chk("wr_data", {24'd0, wr_data}, {24'd0, c_BLANK});
         if (rdy) idx++;
         tick();
         cyc++;
      end
      frame_start = 1'b0;
      wr_ready    = 1'b1;
      chk("sweep_count", idx, total);
      chk("wait_valid",  {31'd0, wr_valid}, 32'd0);
      chk("wait_busy",   {31'd0, busy},     32'd1);
      chk("wait_top",    {27'd0, top_row},  {27'd0, top_keep});
      tick();
      chk("wait_no_ack", {31'd0, ack},      32'd0);
      chk("wait_hold",   {27'd0, top_row},  {27'd0, top_keep});
   endtask

   task automatic commit(input logic [4:0] exp_top);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("ack_pulse",  {31'd0, ack},     32'd1);
      chk("ack_busy",   {31'd0, busy},    32'd1);
      chk("commit_top", {27'd0, top_row}, {27'd0, exp_top});
      tick();
      chk("ack_drop",   {31'd0, ack},     32'd0);
      chk("idle_busy",  {31'd0, busy},    32'd0);
   endtask

   task automatic do_scroll(input logic [4:0] top0, input bit rnd, input bit fsn);
      scroll_req = 1'b1;
      wr_ready   = 1'b1;
      tick();
      scroll_req = 1'b0;
      chk("acc_busy", {31'd0, busy}, 32'd1);
      sweep(1'b0, top0 + c_ROWS5, top0, rnd, fsn);
      commit(top0 + 5'd1);
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      scroll_req  = 1'b0;
      clear_req   = 1'b0;
      wr_ready    = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_top",   {27'd0, top_row},  32'd0);
      chk("rst_ack",   {31'd0, ack},      32'd0);
      chk("rst_busy",  {31'd0, busy},     32'd0);
      chk("rst_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst_row",   {27'd0, wr_row},   32'd0);
      chk("rst_col",   {25'd0, wr_col},   32'd0);
      chk("rst_data",  {24'd0, wr_data},  32'h20);

      // First scroll: row 24, top_row 0 -> 1.
      do_scroll(5'd0, 1'b0, 1'b0);
      for (int t = 1; t < 10; t++) do_scroll(5'(t), 1'b0, 1'b0);
      // top_row=10: recycled row is 2; frame_start noise while blanking.
      chk("pre10_top", {27'd0, top_row}, 32'd10);
      do_scroll(5'd10, 1'b0, 1'b1);
      chk("post10_top", {27'd0, top_row}, 32'd11);
      // Random back-pressure scroll.
      do_scroll(5'd11, 1'b1, 1'b0);
      for (int t = 12; t < 31; t++) do_scroll(5'(t), 1'b0, 1'b0);
      // 31 scrolls from top_row=31; the first wraps to 0.
      chk("pre31_top", {27'd0, top_row}, 32'd31);
      for (int k = 0; k < 31; k++) do_scroll(5'(31 + k), 1'b0, 1'b0);
      chk("post31_top", {27'd0, top_row}, 32'd30);
      for (int k = 0; k < 9; k++) do_scroll(5'(30 + k), 1'b0, 1'b0);
      chk("pre_clr_top", {27'd0, top_row}, 32'd7);

      // Clear and scroll together: clear wins, scroll follows after ack.
      clear_req  = 1'b1;
      scroll_req = 1'b1;
      tick();
      clear_req  = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd1);
      sweep(1'b1, 5'd0, 5'd7, 1'b0, 1'b1);
      commit(5'd0);
      tick();
      scroll_req = 1'b0;
      chk("pend_busy", {31'd0, busy}, 32'd1);
      sweep(1'b0, 5'd24, 5'd0, 1'b0, 1'b0);
      commit(5'd1);

      // Reset in the middle of a clear sweep.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (100) tick();
      chk("mid_valid", {31'd0, wr_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_valid", {31'd0, wr_valid}, 32'd0);
      chk("abort_top",   {27'd0, top_row},  32'd0);
      chk("abort_ack",   {31'd0, ack},      32'd0);
      chk("abort_busy",  {31'd0, busy},     32'd0);
      for (int k = 0; k < 5; k++) begin
         frame_start = 1'b1;
         tick();
         chk("abort_no_ack", {31'd0, ack},      32'd0);
         chk("abort_no_wr",  {31'd0, wr_valid}, 32'd0);
      end
      frame_start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
